pipe_ctrl: RTL and testbench

Pipeline control unit for the 5-stage RISC-V core. Merges per-stage stall requests and the EX-stage jump/branch redirect. Drives the 6-bit stall vector consumed by the PC register and the pipeline registers, the redirect to the PC register, and a timed flush of the front-end pipeline registers. Also tracks consecutive stall cycles and flags a stall timeout.

---
 rtl/pipe_ctrl.sv | 122 ++++++++++++
 tb/tb_pipe_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage core: stall vector merge, EX redirect, timed front-end flush, stall timeout.
// Optional build macro PIPE_CTRL_PERF_EN adds stall/flush performance counters.
module pipe_ctrl #(
    parameter int ADDR_WIDTH    = 32,
    parameter int FLUSH_CYCLES  = 1,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stallreq_id_i,
    input  logic                  stallreq_ex_i,
    input  logic                  stallreq_mem_i,
    input  logic                  jump_req_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    output logic [5:0]            stall_o,
    output logic                  flush_o,
    output logic                  jump_o,
    output logic [ADDR_WIDTH-1:0] jump_addr_o,
    output logic                  stall_err_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]           stall_cnt_o,
    output logic [31:0]           flush_cnt_o
`endif
);

    typedef enum logic {RUN, FLUSH} state_e;

    state_e      state_q, state_d;
    logic [1:0]  flush_left_q, flush_left_d;
    logic [15:0] stall_run_q, stall_run_d;
    logic        err_q, err_d;
    logic        jump_acc, id_mask, flush, exmem_stall, stall_any;
    logic [5:0]  stall_vec;

    assign exmem_stall = stallreq_ex_i | stallreq_mem_i;

    always_comb begin
        state_d      = state_q;
        flush_left_d = flush_left_q;
        jump_acc     = 1'b0;
        id_mask      = 1'b0;
        flush        = 1'b0;
        case (state_q)
            RUN: begin
                if (jump_req_i && !exmem_stall) begin
                    jump_acc = 1'b1;
                    id_mask  = 1'b1;
                    flush    = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d      = FLUSH;
                        flush_left_d = 2'(FLUSH_CYCLES - 1);
                    end
                end
            end
            FLUSH: begin
                id_mask = 1'b1;
                flush   = 1'b1;
                // EX/MEM stall holds the bubbles in place, so the count freezes
                if (!exmem_stall) begin
                    flush_left_d = flush_left_q - 2'd1;
                    if (flush_left_q == 2'd1) state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_vec = 6'b000000;
        if (stallreq_mem_i)                  stall_vec = 6'b011111;
        else if (stallreq_ex_i)              stall_vec = 6'b001111;
        else if (stallreq_id_i && !id_mask)  stall_vec = 6'b000111;
    end

    assign stall_any = |stall_vec;

    always_comb begin
        stall_run_d = 16'd0;
        if (stall_any) stall_run_d = (stall_run_q == 16'hFFFF) ? stall_run_q : stall_run_q + 16'd1;
        // Count includes the current stalled cycle, so the flag lands on the edge that completes the run
        err_d = err_q | (stall_any && (({1'b0, stall_run_q} + 17'd1) >= 17'(STALL_TIMEOUT)));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= RUN;
            flush_left_q <= 2'd0;
            stall_run_q  <= 16'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_left_q <= flush_left_d;
            stall_run_q  <= stall_run_d;
            err_q        <= err_d;
        end
    end

    assign stall_o     = rst_i ? 6'b000000 : stall_vec;
    assign flush_o     = flush & ~rst_i;
    assign jump_o      = jump_acc & ~rst_i;
    assign jump_addr_o = (jump_acc && !rst_i) ? jump_addr_i : '0;
    assign stall_err_o = err_q & ~rst_i;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            if (stall_any) perf_stall_q <= perf_stall_q + 32'd1;
            if (jump_acc)  perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign stall_cnt_o = rst_i ? 32'd0 : perf_stall_q;
    assign flush_cnt_o = rst_i ? 32'd0 : perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: three instances (FLUSH_CYCLES 1/2/3) share stimulus and are compared
// each cycle against a per-instance reference model built on "flush cycles still owed".
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst, id, ex, mem, jr;
    logic [31:0] addr;

    logic [5:0]  st [3];
    logic        fl [3];
    logic        jo [3];
    logic [31:0] ja [3];
    logic        er [3];
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] sc [3];
    logic [31:0] fc [3];
`endif

    int checks = 0;
    int errors = 0;

    // model state
    int          owed   [3];
    int          streak [3];
    bit          err_m  [3];
    int unsigned pst    [3];
    int unsigned pfl    [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pipe_ctrl #(
            .ADDR_WIDTH   (32),
            .FLUSH_CYCLES (g + 1),
            .STALL_TIMEOUT((g == 2) ? 20 : 8)
        ) u_dut (
            .clk_i         (clk),
            .rst_i         (rst),
            .stallreq_id_i (id),
            .stallreq_ex_i (ex),
            .stallreq_mem_i(mem),
            .jump_req_i    (jr),
            .jump_addr_i   (addr),
            .stall_o       (st[g]),
            .flush_o       (fl[g]),
            .jump_o        (jo[g]),
            .jump_addr_o   (ja[g]),
            .stall_err_o   (er[g])
`ifdef PIPE_CTRL_PERF_EN
            ,
            .stall_cnt_o   (sc[g]),
            .flush_cnt_o   (fc[g])
`endif
        );
    end

    function automatic int flush_len(int k);
        return k + 1;
    endfunction

    function automatic int timeout(int k);
        return (k == 2) ? 20 : 8;
    endfunction

    task automatic check(string tag, int k, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d: got %h expected %h", tag, k, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, compare mid-low-phase, advance the model.
    task automatic step(input logic r, input logic i, input logic e, input logic m,
                        input logic j, input logic [31:0] a);
        @(negedge clk);
        rst = r; id = i; ex = e; mem = m; jr = j; addr = a;
        #2;
        for (int k = 0; k < 3; k++) begin
            logic [5:0]  es;
            logic        ef, ej, ee, in_fl, acc;
            logic [31:0] ea;
            in_fl = !r && (owed[k] > 0);
            acc   = !r && !in_fl && j && !e && !m;
            if (r)                            es = 6'h00;
            else if (m)                       es = 6'b011111;
            else if (e)                       es = 6'b001111;
            else if (i && !in_fl && !acc)     es = 6'b000111;
            else                              es = 6'h00;
            ef = in_fl || acc;
            ej = acc;
            ea = acc ? a : 32'h0;
            ee = r ? 1'b0 : err_m[k];
            check("stall", k, 32'(st[k]), 32'(es));
            check("flush", k, 32'(fl[k]), 32'(ef));
            check("jump", k, 32'(jo[k]), 32'(ej));
            check("jump_addr", k, ja[k], ea);
            check("stall_err", k, 32'(er[k]), 32'(ee));
`ifdef PIPE_CTRL_PERF_EN
            check("stall_cnt", k, sc[k], r ? 32'h0 : pst[k]);
            check("flush_cnt", k, fc[k], r ? 32'h0 : pfl[k]);
`endif
            if (r) begin
                owed[k] = 0; streak[k] = 0; err_m[k] = 1'b0; pst[k] = 0; pfl[k] = 0;
            end else begin
                if (acc) begin
                    owed[k] = flush_len(k) - 1;
                    pfl[k]++;
                end else if (in_fl && !e && !m) begin
                    owed[k]--;
                end
                if (es != 6'h00) begin
                    if (streak[k] < 65535) streak[k]++;
                    pst[k]++;
                end else begin
                    streak[k] = 0;
                end
                if (streak[k] >= timeout(k)) err_m[k] = 1'b1;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            owed[k] = 0; streak[k] = 0; err_m[k] = 1'b0; pst[k] = 0; pfl[k] = 0;
        end
        rst = 1'b1; id = 1'b0; ex = 1'b0; mem = 1'b0; jr = 1'b0; addr = 32'h0;

        // reset held with every request high
        repeat (3) step(1, 1, 1, 1, 1, $urandom);
        // release: full stall, jump blocked by MEM for 3 cycles
        repeat (3) step(0, 1, 1, 1, 1, 32'h0000_0200);
        // MEM drops: jump accepted despite the ID request
        step(0, 1, 0, 0, 1, 32'h0000_0200);
        check("accept_after_mem", 1, 32'(jo[1]), 32'h1);
        check("id_vs_jump_stall", 1, 32'(st[1]), 32'h0);
        repeat (3) step(0, 0, 0, 0, 0, 32'h0);

        // priority ladder
        step(0, 1, 0, 0, 0, 32'h0);
        check("prio_id", 0, 32'(st[0]), 32'h07);
        step(0, 1, 1, 0, 0, 32'h0);
        step(0, 1, 1, 1, 0, 32'h0);
        check("prio_mem", 0, 32'(st[0]), 32'h1F);
        step(0, 0, 0, 0, 0, 32'h0);
        check("prio_none", 0, 32'(st[0]), 32'h00);

        // plain jump
        step(0, 0, 0, 0, 1, 32'h0000_0100);
        check("jump_addr_N", 1, ja[1], 32'h0000_0100);
        step(0, 0, 0, 0, 0, 32'h0);
        check("flush_N1", 1, 32'(fl[1]), 32'h1);
        step(0, 0, 0, 0, 0, 32'h0);
        check("flush_N2", 1, 32'(fl[1]), 32'h0);
        repeat (2) step(0, 0, 0, 0, 0, 32'h0);

        // flush frozen by an EX stall, jump and ID request during flush
        step(0, 0, 0, 0, 1, 32'h0000_0340);
        step(0, 1, 1, 0, 0, 32'h0);
        step(0, 0, 1, 0, 1, 32'h0000_0999);
        step(0, 0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0);
        check("flush_freeze_N4", 2, 32'(fl[2]), 32'h1);
        step(0, 0, 0, 0, 0, 32'h0);
        check("flush_freeze_N5", 2, 32'(fl[2]), 32'h0);
        repeat (2) step(0, 0, 0, 0, 0, 32'h0);

        // timeout: 7-cycle run stays clear, 8-cycle run trips
        step(1, 0, 0, 0, 0, 32'h0);
        repeat (7) step(0, 1, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0);
        check("timeout_7", 0, 32'(er[0]), 32'h0);
        repeat (8) step(0, 1, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0);
        check("timeout_8", 0, 32'(er[0]), 32'h1);
        repeat (3) step(0, 0, 0, 0, 0, 32'h0);
        check("timeout_sticky", 0, 32'(er[0]), 32'h1);
        check("timeout_20_clear", 2, 32'(er[2]), 32'h0);

        // randomized traffic, alternating quiet and stall-heavy phases
        step(1, 0, 0, 0, 0, 32'h0);
        for (int ph = 0; ph < 8; ph++) begin
            int heavy;
            heavy = ph % 2;
            for (int c = 0; c < 60; c++) begin
                logic r, i, e, m, j;
                r = ($urandom_range(99) < 2);
                i = ($urandom_range(99) < (heavy ? 70 : 25));
                e = ($urandom_range(99) < (heavy ? 40 : 15));
                m = ($urandom_range(99) < (heavy ? 40 : 10));
                j = ($urandom_range(99) < 35);
                step(r, i, e, m, j, $urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
